// File: rtl/bist_response_analyzer.sv
`default_nettype none
// ============================================================================
// Module   : bist_response_analyzer
// Purpose  : BIST session controller and MISR response compactor. On Start it
//            switches the mode mux to BIST data, waits one settle cycle,
//            compacts PATTERNS response words into an N-bit MISR, compares the
//            result against a golden signature and holds the verdict in DONE
//            until Start is released.
// Ports    : Clk           - sole clock, rising edge
//            Rst           - synchronous active-high reset
//            Start         - level request for one BIST session
//            From_Logic    - [N-1:0] core-logic response bits
//            Expected_Sig  - [N-1:0] golden signature, sampled in COMPARE
//            BIST_Mode_Sel - mode mux select, 1 = BIST data feeds logic
//            Busy          - high in SETTLE, CAPTURE, COMPARE
//            Done          - high in DONE
//            Pass          - compare verdict, valid while Done = 1
//            Signature     - [N-1:0] MISR contents, or zeros (see macro)
// Config   : BIST_SIGNATURE_OUT_EN - when defined, Signature exposes the MISR;
//            otherwise Signature is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module bist_response_analyzer #(
  parameter int          N        = 6,
  parameter int          PATTERNS = 64,
  parameter logic [N-1:0] TAPS    = 6'b000011
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         Start,
  input  logic [N-1:0] From_Logic,
  input  logic [N-1:0] Expected_Sig,
  output logic         BIST_Mode_Sel,
  output logic         Busy,
  output logic         Done,
  output logic         Pass,
  output logic [N-1:0] Signature
);

  localparam int          CW   = $clog2(PATTERNS + 1);
  localparam logic [CW-1:0] LAST = CW'(PATTERNS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE  = 3'd1,
    S_CAPTURE = 3'd2,
    S_COMPARE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t        state;
  logic [N-1:0]  misr;
  logic [N-1:0]  misr_next;
  logic [CW-1:0] cnt;

  // Shift towards the MSB with a zero entering bit 0, fold in the response
  // word, and apply the feedback taps when the outgoing MSB is set.
  always_comb begin
    misr_next = {misr[N-2:0], 1'b0} ^ From_Logic ^ (TAPS & {N{misr[N-1]}});
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state         <= S_IDLE;
      misr          <= '0;
      cnt           <= '0;
      Pass          <= 1'b0;
      Busy          <= 1'b0;
      Done          <= 1'b0;
      BIST_Mode_Sel <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Start) begin
            state         <= S_SETTLE;
            misr          <= '0;
            cnt           <= '0;
            Pass          <= 1'b0;
            Busy          <= 1'b1;
            BIST_Mode_Sel <= 1'b1;
          end
        end
        // One cycle for the mode mux to switch before responses are trusted.
        S_SETTLE: begin
          state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          misr <= misr_next;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          Pass          <= (misr == Expected_Sig);
          state         <= S_DONE;
          Busy          <= 1'b0;
          BIST_Mode_Sel <= 1'b0;
          Done          <= 1'b1;
        end
        // Holding Start high here must not start a second session, so the
        // return to IDLE waits for Start to drop.
        S_DONE: begin
          if (!Start) begin
            state <= S_IDLE;
            Done  <= 1'b0;
          end
        end
        default: begin
          state         <= S_IDLE;
          Busy          <= 1'b0;
          Done          <= 1'b0;
          BIST_Mode_Sel <= 1'b0;
        end
      endcase
    end
  end

`ifdef BIST_SIGNATURE_OUT_EN
  assign Signature = misr;
`else
  assign Signature = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bist_response_analyzer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bist_response_analyzer
// Purpose  : Self-checking bench. Two analyzer instances (PATTERNS = 4 and
//            PATTERNS = 1) share the same stimulus; a session-position model
//            predicts every output each cycle, and directed runs pin the
//            model with hand-computed literal values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bist_response_analyzer;

  localparam logic [5:0] TAPS = 6'b000011;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       Start = 1'b0;
  logic [5:0] From_Logic = '0;
  logic [5:0] Expected_Sig = '0;

  logic       mode_o [2];
  logic       busy_o [2];
  logic       done_o [2];
  logic       pass_o [2];
  logic [5:0] sig_o  [2];

  always #5 Clk = ~Clk;

  bist_response_analyzer #(.N(6), .PATTERNS(4), .TAPS(TAPS)) u_dut4 (
    .Clk(Clk), .Rst(Rst), .Start(Start), .From_Logic(From_Logic),
    .Expected_Sig(Expected_Sig), .BIST_Mode_Sel(mode_o[0]), .Busy(busy_o[0]),
    .Done(done_o[0]), .Pass(pass_o[0]), .Signature(sig_o[0])
  );

  bist_response_analyzer #(.N(6), .PATTERNS(1), .TAPS(TAPS)) u_dut1 (
    .Clk(Clk), .Rst(Rst), .Start(Start), .From_Logic(From_Logic),
    .Expected_Sig(Expected_Sig), .BIST_Mode_Sel(mode_o[1]), .Busy(busy_o[1]),
    .Done(done_o[1]), .Pass(pass_o[1]), .Signature(sig_o[1])
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  // A session is tracked by its position k: 0 = settle cycle, 1..P = capture
  // cycles, P+1 = compare cycle; after that the session is finished.
  int         pat [2] = '{4, 1};
  bit         m_act  [2];
  int         m_k    [2];
  bit         m_done [2];
  bit         m_pass [2];
  logic [5:0] m_s    [2];

  function automatic logic [5:0] misr_step(input logic [5:0] s, input logic [5:0] f);
    logic [5:0] shifted;
    shifted = s << 1;
    return shifted ^ f ^ (s[5] ? TAPS : 6'b0);
  endfunction

  function automatic logic [5:0] exp_sig(input logic [5:0] s);
`ifdef BIST_SIGNATURE_OUT_EN
    return s;
`else
    return (s & 6'b0);
`endif
  endfunction

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_k[i] = 0; m_done[i] = 0; m_pass[i] = 0; m_s[i] = '0;
    end
  end

  always @(posedge Clk) begin
    for (int i = 0; i < 2; i++) begin
      if (Rst) begin
        m_act[i] <= 0; m_k[i] <= 0; m_done[i] <= 0; m_pass[i] <= 0; m_s[i] <= '0;
      end else if (m_done[i]) begin
        if (!Start) m_done[i] <= 0;
      end else if (m_act[i]) begin
        m_k[i] <= m_k[i] + 1;
        if (m_k[i] >= 1 && m_k[i] <= pat[i]) m_s[i] <= misr_step(m_s[i], From_Logic);
        if (m_k[i] == pat[i] + 1) begin
          m_pass[i] <= (m_s[i] == Expected_Sig);
          m_act[i]  <= 0;
          m_done[i] <= 1;
        end
      end else if (Start) begin
        m_act[i] <= 1; m_k[i] <= 0; m_s[i] <= '0; m_pass[i] <= 0;
      end
    end
  end

  bit cmp_en = 0;

  always @(negedge Clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("busy[%0d]", i), int'(busy_o[i]), int'(m_act[i]));
        chk($sformatf("mode[%0d]", i), int'(mode_o[i]), int'(m_act[i]));
        chk($sformatf("done[%0d]", i), int'(done_o[i]), int'(m_done[i]));
        chk($sformatf("pass[%0d]", i), int'(pass_o[i]), int'(m_pass[i]));
        chk($sformatf("sig[%0d]", i), int'(sig_o[i]), int'(exp_sig(m_s[i])));
      end
    end
  end

  // ------------------------------------------------------------ directed
  int bcnt0, bcnt1;

  // Raise Start, count Busy cycles of both instances until the longer one
  // reports Done, with a bounded wait.
  task automatic run_session;
    Start = 1'b1;
    bcnt0 = 0;
    bcnt1 = 0;
    for (int i = 0; i < 40 && !done_o[0]; i++) begin
      @(negedge Clk);
      if (busy_o[0]) bcnt0++;
      if (busy_o[1]) bcnt1++;
    end
    chk("session_done_reached", int'(done_o[0]), 1);
  endtask

  task automatic release_start;
    Start = 1'b0;
    @(negedge Clk);
    chk("idle_after_release", int'(done_o[0]), 0);
  endtask

  initial begin
    Rst = 1'b1;
    @(posedge Clk);
    cmp_en = 1;
    @(negedge Clk);
    @(negedge Clk);
    chk("rst_busy", int'(busy_o[0]), 0);
    chk("rst_done", int'(done_o[0]), 0);
    chk("rst_pass", int'(pass_o[0]), 0);
    chk("rst_mode", int'(mode_o[0]), 0);
    chk("rst_sig", int'(sig_o[0]), 0);
    Rst = 1'b0;

    // All-zero responses against a zero golden signature.
    From_Logic = 6'b0; Expected_Sig = 6'b0;
    run_session();
    chk("zero_busy_cycles_p4", bcnt0, 6);
    chk("zero_busy_cycles_p1", bcnt1, 3);
    chk("zero_pass", int'(pass_o[0]), 1);
    chk("zero_sig", int'(sig_o[0]), 0);
    // Start held through DONE must not retrigger.
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      chk("hold_done", int'(done_o[0]), 1);
      chk("hold_mode", int'(mode_o[0]), 0);
      chk("hold_busy", int'(busy_o[0]), 0);
    end
    release_start();
    chk("release_mode", int'(mode_o[0]), 0);

    // Constant 000001 responses: signature 001111 after four captures.
    From_Logic = 6'b000001; Expected_Sig = 6'b001111;
    run_session();
`ifdef BIST_SIGNATURE_OUT_EN
    chk("ones_sig_p4", int'(sig_o[0]), 6'b001111);
    chk("ones_sig_p1", int'(sig_o[1]), 6'b000001);
`else
    chk("ones_sig_p4", int'(sig_o[0]), 0);
    chk("ones_sig_p1", int'(sig_o[1]), 0);
`endif
    chk("ones_pass_p4", int'(pass_o[0]), 1);
    chk("ones_pass_p1", int'(pass_o[1]), 0);
    release_start();

    From_Logic = 6'b000001; Expected_Sig = 6'b001110;
    run_session();
    chk("ones_badgold_pass", int'(pass_o[0]), 0);
    release_start();
    chk("pass_kept_in_idle", int'(pass_o[0]), 0);

    // Single capture on the PATTERNS=1 instance.
    From_Logic = 6'b100000; Expected_Sig = 6'b100000;
    run_session();
    chk("p1_busy_cycles", bcnt1, 3);
    chk("p1_pass", int'(pass_o[1]), 1);
`ifdef BIST_SIGNATURE_OUT_EN
    chk("p1_sig", int'(sig_o[1]), 6'b100000);
`else
    chk("p1_sig", int'(sig_o[1]), 0);
`endif
    release_start();
    chk("pass_kept_in_idle_p1", int'(pass_o[1]), 1);

    // Reset during the second capture cycle aborts the session.
    From_Logic = 6'b010101;
    Start = 1'b1;
    repeat (3) @(negedge Clk);   // settle, capture 1, capture 2 in progress
    chk("abort_busy_before", int'(busy_o[0]), 1);
    Start = 1'b0;
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    chk("abort_busy", int'(busy_o[0]), 0);
    chk("abort_mode", int'(mode_o[0]), 0);
    chk("abort_pass", int'(pass_o[0]), 0);
    chk("abort_sig", int'(sig_o[0]), 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      chk("abort_no_done", int'(done_o[0]), 0);
    end
    run_session();
    chk("fresh_busy_cycles", bcnt0, 6);
    release_start();

    // Randomized traffic; the compare process checks every cycle.
    for (int c = 0; c < 2000; c++) begin
      From_Logic = 6'($urandom);
      Expected_Sig = ($urandom_range(0, 1) == 1) ? m_s[0] : 6'($urandom);
      if ($urandom_range(0, 7) == 0) Start = ~Start;
      Rst = ($urandom_range(0, 99) == 0);
      @(negedge Clk);
    end
    Rst = 1'b0;
    Start = 1'b0;
    repeat (3) @(negedge Clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bist_response_analyzer.md
BIST_RESPONSE_ANALYZER -- requirements
Module: bist_response_analyzer

Interface
REQ-001 The block SHALL have parameter N, default 6, giving the width of the logic-output bus under test.
REQ-002 The block SHALL have parameter PATTERNS, default 64, legal range 1..65535, giving the number of capture cycles.
REQ-003 The block SHALL have parameter TAPS, default 6'b000011 (x^6+x+1), N bits wide, giving the MISR feedback taps.
REQ-004 Clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Rst  input  1  synchronous reset, active-high.
REQ-006 Start  input  1  level request to run one BIST session.
REQ-007 From_Logic  input  N  core-logic response bits to be compacted.
REQ-008 Expected_Sig  input  N  golden signature, sampled in COMPARE.
REQ-009 BIST_Mode_Sel  output  1  drives the BIST/BSC mode mux select; 1 = BIST data feeds logic.
REQ-010 Busy  output  1  high in SETTLE, CAPTURE and COMPARE.
REQ-011 Done  output  1  high in DONE only.
REQ-012 Pass  output  1  compare result, valid while Done=1.
REQ-013 Signature  output  N  MISR contents (see Configuration).

Function
REQ-014 FSM states SHALL be IDLE, SETTLE, CAPTURE, COMPARE, DONE.
REQ-015 IDLE->SETTLE SHALL occur on the first edge with Start=1; the MISR SHALL clear to 0 and the pattern counter to 0 on that edge.
REQ-016 SETTLE SHALL last exactly one cycle (mux switch latency) and then go to CAPTURE; no compaction in SETTLE.
REQ-017 In CAPTURE, each cycle SHALL update MISR: S'[i] = S[i-1] ^ From_Logic[i] ^ (TAPS[i] & S[N-1]), with S[-1] = 0.
REQ-018 CAPTURE SHALL last exactly PATTERNS cycles, counted by a counter of ceil(log2(PATTERNS+1)) bits; at count PATTERNS-1 the next state is COMPARE (PATTERNS=1 gives one capture cycle).
REQ-019 COMPARE SHALL last one cycle; on its exit edge Pass SHALL be registered as (MISR == Expected_Sig).
REQ-020 DONE SHALL hold Done=1, Pass and the MISR until Start=0, then return to IDLE on the next edge.
REQ-021 Pass SHALL keep its last value in IDLE and SHALL clear to 0 on IDLE->SETTLE.
REQ-022 BIST_Mode_Sel SHALL be 1 in SETTLE, CAPTURE and COMPARE, and 0 in IDLE and DONE.
REQ-023 Start toggling while Busy=1 SHALL be ignored; Start held high through DONE SHALL NOT retrigger a session.
REQ-024 All outputs SHALL be registered or decoded from registered state only; no combinational path from input to output.

Reset
REQ-025 Rst=1 SHALL force IDLE, MISR=0, counter=0, Pass=0, Busy=0, Done=0, BIST_Mode_Sel=0 on the next edge, overriding all other inputs.
REQ-026 Rst asserted mid-session SHALL abort it with no Done pulse; a new session SHALL need Start=1 after Rst falls.

Configuration
REQ-027 With macro BIST_SIGNATURE_OUT_EN defined, Signature SHALL continuously reflect the MISR register.
REQ-028 Without BIST_SIGNATURE_OUT_EN, Signature SHALL be tied to all zeros and Pass/Done behaviour SHALL be unchanged.

Verification
REQ-029 Rst, then Start=1 with N=6, PATTERNS=4, From_Logic=0 constant, Expected_Sig=0 -> Busy for 6 cycles, Done=1, Pass=1, Signature=0.
REQ-030 Same run with From_Logic=6'b000001 every cycle -> Signature=6'b001111, Pass=1 when Expected_Sig=6'b001111, Pass=0 when Expected_Sig=6'b001110.
REQ-031 Rst pulsed during cycle 2 of CAPTURE -> next cycle all outputs at reset values; no Done; a fresh Start gives a full 6-cycle session.
REQ-032 Start held high through DONE for 10 cycles -> Done stays 1, no second session; Start=0 -> IDLE after one edge, BIST_Mode_Sel=0 throughout.
REQ-033 PATTERNS=1, From_Logic=6'b100000 -> exactly one capture cycle, Signature=6'b100000, Busy for 3 cycles.
REQ-034 Build without BIST_SIGNATURE_OUT_EN, rerun REQ-030 -> Signature=0, Pass results identical.
